// File: rtl/ysyx_22040632_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_wbu -- write-back and next-PC unit
//
// Owns the architectural PC and the 32x64 general-purpose register file.
// Offers the PC to instruction fetch, accepts one execute result per
// instruction, and commits it (GPR write, PC update, retire count). A
// three-state FSM (FETCH -> EXEC -> FETCH, HALT on trap) sequences the two
// handshakes, so each instruction takes at least two cycles.
//
// Optional feature macro: YSYX_22040632_ALIGN_CHECK_EN
//   defined     : a taken jump whose target has bit 1 set suppresses the
//                 whole commit, sets the sticky trap flag and parks in HALT.
//   not defined : trap is tied 0, HALT is unreachable, target bit 1 is
//                 taken into the PC as-is.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   pc_out/pc_valid  current PC offered to IFU
//   pc_ready         IFU accepts pc_out
//   ex_valid/ex_ready execute result handshake
//   ex_wen/ex_rd/ex_data  GPR write request carried by the result
//   ex_pcchg/ex_pc_target taken control transfer and its target
//   rs1_addr/rs1_data, rs2_addr/rs2_data  combinational GPR read ports
//   retired          count of committed instructions (wraps)
//   trap             sticky misaligned-target flag
// ---------------------------------------------------------------------------
module ysyx_22040632_wbu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_out,
  output logic        pc_valid,
  input  logic        pc_ready,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_wen,
  input  logic [4:0]  ex_rd,
  input  logic [63:0] ex_data,
  input  logic        ex_pcchg,
  input  logic [63:0] ex_pc_target,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [63:0] rs1_data,
  output logic [63:0] rs2_data,
  output logic [63:0] retired,
  output logic        trap
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [63:0] gpr [32];
  logic        commit;     // execute result accepted this cycle
  logic        commit_ok;  // accepted and allowed to update state
  logic        trap_set;
  logic        misaligned;
  logic [63:0] pc_next;

  // Jump targets are halfword aligned by construction; bit 0 is always
  // cleared, so it never reaches the PC.
  logic unused_target_lsb;
  assign unused_target_lsb = ex_pc_target[0];

`ifdef YSYX_22040632_ALIGN_CHECK_EN
  assign misaligned = ex_pcchg & ex_pc_target[1];
`else
  assign misaligned = 1'b0;
`endif

  assign pc_next = ex_pcchg ? {ex_pc_target[63:1], 1'b0} : pc_out + 64'd4;

  // -------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next = state;
    pc_valid   = 1'b0;
    ex_ready   = 1'b0;
    commit     = 1'b0;
    commit_ok  = 1'b0;
    trap_set   = 1'b0;
    unique case (state)
      FETCH: begin
        pc_valid = 1'b1;
        if (pc_ready) state_next = EXEC;
      end
      EXEC: begin
        ex_ready = 1'b1;
        if (ex_valid) begin
          commit     = 1'b1;
          commit_ok  = ~misaligned;
          trap_set   = misaligned;
          state_next = misaligned ? HALT : FETCH;
        end
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase
    // Handshake outputs are held low for the whole reset cycle so neither
    // neighbour sees a transfer while state is being reloaded.
    if (rst) begin
      pc_valid = 1'b0;
      ex_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // -------------------------------------------------------------------------
  // Architectural state: PC, retire counter, register file
  // -------------------------------------------------------------------------
  // NOTE: the register file is reset as flip-flops rather than RAM because
  // software relies on every GPR reading 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out  <= RESET_PC;
      retired <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (commit_ok) begin
      pc_out  <= pc_next;
      retired <= retired + 64'd1;
      if (ex_wen && ex_rd != 5'd0) gpr[ex_rd] <= ex_data;
    end
  end

`ifdef YSYX_22040632_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)           trap <= 1'b0;
    else if (trap_set) trap <= 1'b1;
  end
`else
  logic unused_trap;
  assign unused_trap = trap_set ^ commit;
  assign trap        = 1'b0;
`endif

  // x0 is never written, but the explicit zero keeps the read side correct
  // independent of what the array holds at index 0.
  assign rs1_data = (rs1_addr == 5'd0) ? 64'd0 : gpr[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 64'd0 : gpr[rs2_addr];

endmodule

// File: tb/tb_ysyx_22040632_wbu.sv
// ---------------------------------------------------------------------------
// Directed testbench for ysyx_22040632_wbu. Inputs change 1 time unit after
// each rising edge and outputs are sampled at that same point, well clear of
// the next edge.
// ---------------------------------------------------------------------------
module tb_ysyx_22040632_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_out;
  logic        pc_valid;
  logic        pc_ready;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_wen;
  logic [4:0]  ex_rd;
  logic [63:0] ex_data;
  logic        ex_pcchg;
  logic [63:0] ex_pc_target;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] retired;
  logic        trap;

  int n_cmp = 0;
  int n_mis = 0;

  ysyx_22040632_wbu dut (
    .clk          (clk),
    .rst          (rst),
    .pc_out       (pc_out),
    .pc_valid     (pc_valid),
    .pc_ready     (pc_ready),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_wen       (ex_wen),
    .ex_rd        (ex_rd),
    .ex_data      (ex_data),
    .ex_pcchg     (ex_pcchg),
    .ex_pc_target (ex_pc_target),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .retired      (retired),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH handshake: one cycle with pc_ready high.
  task automatic do_fetch();
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
  endtask

  // EXEC commit: one cycle with ex_valid high and the given payload.
  task automatic do_commit(input logic wen, input logic [4:0] rd,
                           input logic [63:0] data, input logic pcchg,
                           input logic [63:0] target);
    ex_valid     = 1'b1;
    ex_wen       = wen;
    ex_rd        = rd;
    ex_data      = data;
    ex_pcchg     = pcchg;
    ex_pc_target = target;
    tick();
    ex_valid = 1'b0;
    ex_wen   = 1'b0;
    ex_pcchg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pc_ready = 1'b1;
    tick();
    n_cmp++; if (pc_valid !== 1'b0) begin n_mis++; $display("FAIL reset_pc_valid_low: got %b want 0", pc_valid); end
    n_cmp++; if (ex_ready !== 1'b0) begin n_mis++; $display("FAIL reset_ex_ready_low: got %b want 0", ex_ready); end
    tick();
    rst = 1'b0;
    pc_ready = 1'b0;
    rs1_addr = 5'd5;
    #1;
    n_cmp++; if (pc_out !== 64'h8000_0000) begin n_mis++; $display("FAIL reset_pc: got %h want 8000_0000", pc_out); end
    n_cmp++; if (pc_valid !== 1'b1) begin n_mis++; $display("FAIL reset_pc_valid: got %b want 1", pc_valid); end
    n_cmp++; if (ex_ready !== 1'b0) begin n_mis++; $display("FAIL reset_ex_ready: got %b want 0", ex_ready); end
    n_cmp++; if (retired !== 64'd0) begin n_mis++; $display("FAIL reset_retired: got %0d want 0", retired); end
    n_cmp++; if (rs1_data !== 64'd0) begin n_mis++; $display("FAIL reset_gpr5: got %h want 0", rs1_data); end
    n_cmp++; if (trap !== 1'b0) begin n_mis++; $display("FAIL reset_trap: got %b want 0", trap); end
  endtask

  task automatic test_sequential();
    do_fetch();
    n_cmp++; if (ex_ready !== 1'b1) begin n_mis++; $display("FAIL seq_exec_ready: got %b want 1", ex_ready); end
    n_cmp++; if (pc_valid !== 1'b0) begin n_mis++; $display("FAIL seq_exec_pc_valid: got %b want 0", pc_valid); end
    do_commit(1'b1, 5'd3, 64'h1234, 1'b0, 64'h0);
    rs1_addr = 5'd3;
    rs2_addr = 5'd3;
    #1;
    n_cmp++; if (rs1_data !== 64'h1234) begin n_mis++; $display("FAIL seq_rs1_x3: got %h want 1234", rs1_data); end
    n_cmp++; if (rs2_data !== 64'h1234) begin n_mis++; $display("FAIL seq_rs2_x3: got %h want 1234", rs2_data); end
    n_cmp++; if (pc_out !== 64'h8000_0004) begin n_mis++; $display("FAIL seq_pc: got %h want 8000_0004", pc_out); end
    n_cmp++; if (retired !== 64'd1) begin n_mis++; $display("FAIL seq_retired: got %0d want 1", retired); end
    n_cmp++; if (pc_valid !== 1'b1) begin n_mis++; $display("FAIL seq_back_to_fetch: got %b want 1", pc_valid); end
  endtask

  task automatic test_x0_jalr();
    do_fetch();
    do_commit(1'b1, 5'd0, 64'hFF, 1'b1, 64'h8000_0101);
    rs1_addr = 5'd0;
    #1;
    n_cmp++; if (rs1_data !== 64'd0) begin n_mis++; $display("FAIL x0_read: got %h want 0", rs1_data); end
    n_cmp++; if (pc_out !== 64'h8000_0100) begin n_mis++; $display("FAIL jalr_lsb: got %h want 8000_0100", pc_out); end
    n_cmp++; if (retired !== 64'd2) begin n_mis++; $display("FAIL jalr_retired: got %0d want 2", retired); end
  endtask

  task automatic test_stalls();
    // FETCH stall with a spurious execute result on the bus.
    pc_ready     = 1'b0;
    ex_valid     = 1'b1;
    ex_wen       = 1'b1;
    ex_rd        = 5'd9;
    ex_data      = 64'hDEAD;
    ex_pcchg     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (pc_out !== 64'h8000_0100) begin n_mis++; $display("FAIL fetch_stall_pc[%0d]: got %h want 8000_0100", i, pc_out); end
    end
    n_cmp++; if (pc_valid !== 1'b1) begin n_mis++; $display("FAIL fetch_stall_valid: got %b want 1", pc_valid); end
    ex_valid = 1'b0;
    ex_wen   = 1'b0;
    rs1_addr = 5'd9;
    #1;
    n_cmp++; if (rs1_data !== 64'd0) begin n_mis++; $display("FAIL fetch_stall_nowrite: got %h want 0", rs1_data); end
    n_cmp++; if (retired !== 64'd2) begin n_mis++; $display("FAIL fetch_stall_retired: got %0d want 2", retired); end
    // EXEC stall: no result for three cycles, pc_ready ignored.
    do_fetch();
    pc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ex_ready !== 1'b1) begin n_mis++; $display("FAIL exec_stall_ready[%0d]: got %b want 1", i, ex_ready); end
    end
    pc_ready = 1'b0;
    n_cmp++; if (pc_out !== 64'h8000_0100) begin n_mis++; $display("FAIL exec_stall_pc: got %h want 8000_0100", pc_out); end
    n_cmp++; if (retired !== 64'd2) begin n_mis++; $display("FAIL exec_stall_retired: got %0d want 2", retired); end
    do_commit(1'b1, 5'd9, 64'hA5A5, 1'b0, 64'h0);
    #1;
    n_cmp++; if (rs1_data !== 64'hA5A5) begin n_mis++; $display("FAIL exec_stall_x9: got %h want a5a5", rs1_data); end
    n_cmp++; if (pc_out !== 64'h8000_0104) begin n_mis++; $display("FAIL exec_stall_pc_after: got %h want 8000_0104", pc_out); end
  endtask

  task automatic test_back_to_back();
    do_fetch();
    do_commit(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0);
    do_fetch();
    do_commit(1'b1, 5'd1, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0);
    do_fetch();
    do_commit(1'b0, 5'd3, 64'h5555, 1'b0, 64'h0);  // wen=0 must not write
    rs1_addr = 5'd31;
    rs2_addr = 5'd1;
    #1;
    n_cmp++; if (rs1_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_mis++; $display("FAIL b2b_x31: got %h want ffffffffffffffff", rs1_data); end
    n_cmp++; if (rs2_data !== 64'h0123_4567_89AB_CDEF) begin n_mis++; $display("FAIL b2b_x1: got %h want 0123456789abcdef", rs2_data); end
    rs1_addr = 5'd3;
    #1;
    n_cmp++; if (rs1_data !== 64'h1234) begin n_mis++; $display("FAIL b2b_wen0: got %h want 1234", rs1_data); end
    n_cmp++; if (pc_out !== 64'h8000_0110) begin n_mis++; $display("FAIL b2b_pc: got %h want 8000_0110", pc_out); end
    n_cmp++; if (retired !== 64'd6) begin n_mis++; $display("FAIL b2b_retired: got %0d want 6", retired); end
  endtask

  task automatic test_reset_mid_commit();
    do_fetch();
    ex_valid     = 1'b1;
    ex_wen       = 1'b1;
    ex_rd        = 5'd7;
    ex_data      = 64'h77;
    ex_pcchg     = 1'b0;
    rst          = 1'b1;
    tick();
    rst      = 1'b0;
    ex_valid = 1'b0;
    ex_wen   = 1'b0;
    rs1_addr = 5'd7;
    rs2_addr = 5'd9;
    #1;
    n_cmp++; if (rs1_data !== 64'd0) begin n_mis++; $display("FAIL rstmid_x7: got %h want 0", rs1_data); end
    n_cmp++; if (rs2_data !== 64'd0) begin n_mis++; $display("FAIL rstmid_x9_cleared: got %h want 0", rs2_data); end
    n_cmp++; if (pc_out !== 64'h8000_0000) begin n_mis++; $display("FAIL rstmid_pc: got %h want 8000_0000", pc_out); end
    n_cmp++; if (retired !== 64'd0) begin n_mis++; $display("FAIL rstmid_retired: got %0d want 0", retired); end
    n_cmp++; if (pc_valid !== 1'b1) begin n_mis++; $display("FAIL rstmid_fetch: got %b want 1", pc_valid); end
  endtask

  task automatic test_pc_wrap();
    do_fetch();
    do_commit(1'b0, 5'd0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    n_cmp++; if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_mis++; $display("FAIL wrap_jump: got %h want fffffffffffffffc", pc_out); end
    do_fetch();
    do_commit(1'b1, 5'd2, 64'h5, 1'b0, 64'h0);
    n_cmp++; if (pc_out !== 64'd0) begin n_mis++; $display("FAIL wrap_pc: got %h want 0", pc_out); end
    n_cmp++; if (retired !== 64'd2) begin n_mis++; $display("FAIL wrap_retired: got %0d want 2", retired); end
  endtask

  task automatic test_misaligned();
    do_fetch();
    do_commit(1'b1, 5'd4, 64'h44, 1'b1, 64'h8000_0002);
    rs1_addr = 5'd4;
    pc_ready = 1'b1;
    #1;
`ifdef YSYX_22040632_ALIGN_CHECK_EN
    n_cmp++; if (trap !== 1'b1) begin n_mis++; $display("FAIL mis_trap: got %b want 1", trap); end
    n_cmp++; if (pc_out !== 64'd0) begin n_mis++; $display("FAIL mis_pc_held: got %h want 0", pc_out); end
    n_cmp++; if (retired !== 64'd2) begin n_mis++; $display("FAIL mis_retired: got %0d want 2", retired); end
    n_cmp++; if (rs1_data !== 64'd0) begin n_mis++; $display("FAIL mis_nowrite: got %h want 0", rs1_data); end
    tick();
    tick();
    n_cmp++; if (pc_valid !== 1'b0) begin n_mis++; $display("FAIL halt_pc_valid: got %b want 0", pc_valid); end
    n_cmp++; if (ex_ready !== 1'b0) begin n_mis++; $display("FAIL halt_ex_ready: got %b want 0", ex_ready); end
    n_cmp++; if (trap !== 1'b1) begin n_mis++; $display("FAIL halt_trap_sticky: got %b want 1", trap); end
`else
    n_cmp++; if (trap !== 1'b0) begin n_mis++; $display("FAIL mis_trap: got %b want 0", trap); end
    n_cmp++; if (pc_out !== 64'h8000_0002) begin n_mis++; $display("FAIL mis_pc: got %h want 8000_0002", pc_out); end
    n_cmp++; if (retired !== 64'd3) begin n_mis++; $display("FAIL mis_retired: got %0d want 3", retired); end
    n_cmp++; if (rs1_data !== 64'h44) begin n_mis++; $display("FAIL mis_write: got %h want 44", rs1_data); end
    n_cmp++; if (pc_valid !== 1'b1) begin n_mis++; $display("FAIL mis_fetch: got %b want 1", pc_valid); end
`endif
    pc_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    pc_ready     = 1'b0;
    ex_valid     = 1'b0;
    ex_wen       = 1'b0;
    ex_rd        = 5'd0;
    ex_data      = 64'd0;
    ex_pcchg     = 1'b0;
    ex_pc_target = 64'd0;
    rs1_addr     = 5'd0;
    rs2_addr     = 5'd0;
    test_reset();
    test_sequential();
    test_x0_jalr();
    test_stalls();
    test_back_to_back();
    test_reset_mid_commit();
    test_pc_wrap();
    test_misaligned();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
